// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32M definitions: word width, muldiv opcodes/states, special-case constants.
// Optional build macro FAST_MUL_EN is consumed by ex_muldiv_unit.
package riscv_defines;

    localparam int WORD_WIDTH = 32;
    localparam int CNT_WIDTH  = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [WORD_WIDTH-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [WORD_WIDTH-1:0] INT_MIN       = {1'b1, {(WORD_WIDTH-1){1'b0}}};

    function automatic logic op_a_signed(muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage muldiv request/response bundle between the pipeline (master) and the unit (slave).
// Handshake: start_i is a level request from ID/EX; busy_o high stalls ID/EX so the request holds;
// done_o is a one-cycle pulse with result_o valid, and result_o holds until the next completion.
interface ex_muldiv_unit_if;
    import riscv_defines::*;

    logic                  start_i;
    muldiv_op_e            op_i;
    logic [WORD_WIDTH-1:0] opa_i;
    logic [WORD_WIDTH-1:0] opb_i;
    logic                  flush_i;
    logic                  busy_o;
    logic                  done_o;
    logic [WORD_WIDTH-1:0] result_o;
    muldiv_state_e         state_dbg;

    modport master (
        output start_i, op_i, opa_i, opb_i, flush_i,
        input  busy_o, done_o, result_o, state_dbg
    );

    modport slave (
        input  start_i, op_i, opa_i, opb_i, flush_i,
        output busy_o, done_o, result_o, state_dbg
    );

endinterface

// File: rtl/ex_muldiv_unit_signfix.sv
// Conditional two's-complement negation: operand absolute value on the way in,
// sign restoration of the product/quotient/remainder on the way out.
module ex_muldiv_unit_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + {{(W-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, early-out specials.
// Define FAST_MUL_EN to replace the iterative multiply with a single-cycle 33x33 signed multiplier.
module ex_muldiv_unit
    import riscv_defines::*;
(
    input  logic                clk,
    input  logic                rst,
    ex_muldiv_unit_if.slave     bus
);

    localparam int DW = 2 * WORD_WIDTH;

    muldiv_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    muldiv_op_e            op_q, op_d;
    logic [WORD_WIDTH-1:0] opnd_q, opnd_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic                  neg_q, neg_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  busy;

    logic                  a_neg, b_neg, res_neg;
    logic [WORD_WIDTH-1:0] abs_a, abs_b;

    assign a_neg   = op_a_signed(bus.op_i) & bus.opa_i[WORD_WIDTH-1];
    assign b_neg   = op_b_signed(bus.op_i) & bus.opb_i[WORD_WIDTH-1];
    // Remainder follows the dividend only; everything else is the XOR of operand signs.
    assign res_neg = a_neg ^ (b_neg & ~(bus.op_i[2] & bus.op_i[1]));

    ex_muldiv_unit_signfix #(.W(WORD_WIDTH)) u_abs_a (.value(bus.opa_i), .negate(a_neg), .result(abs_a));
    ex_muldiv_unit_signfix #(.W(WORD_WIDTH)) u_abs_b (.value(bus.opb_i), .negate(b_neg), .result(abs_b));

    // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    logic [WORD_WIDTH:0]   mul_sum;
    logic [DW-1:0]         mul_next;
    logic [WORD_WIDTH:0]   div_shift;
    logic                  div_ge;
    logic [WORD_WIDTH-1:0] div_rem;
    logic [DW-1:0]         div_next;

    assign mul_sum   = {1'b0, acc_q[DW-1:WORD_WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WORD_WIDTH-1:1]};
    assign div_shift = {acc_q[DW-1:WORD_WIDTH], acc_q[WORD_WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_rem   = div_ge ? (div_shift[WORD_WIDTH-1:0] - opnd_q) : div_shift[WORD_WIDTH-1:0];
    assign div_next  = {div_rem, acc_q[WORD_WIDTH-2:0], div_ge};

    logic [DW-1:0]         fix_in, fix_out;
    logic [WORD_WIDTH-1:0] final_res;

    always_comb begin
        fix_in = {{WORD_WIDTH{1'b0}}, div_next[WORD_WIDTH-1:0]};
        if (state_q == MUL) begin
            fix_in = mul_next;
        end else if (op_q[1]) begin
            fix_in = {{WORD_WIDTH{1'b0}}, div_next[DW-1:WORD_WIDTH]};
        end
    end

    ex_muldiv_unit_signfix #(.W(DW)) u_fix_res (.value(fix_in), .negate(neg_q), .result(fix_out));

    assign final_res = ((state_q == MUL) && (op_q != OP_MUL)) ? fix_out[DW-1:WORD_WIDTH]
                                                               : fix_out[WORD_WIDTH-1:0];

`ifdef FAST_MUL_EN
    logic signed [DW-1:0]  fast_a, fast_b, fast_p;
    logic [WORD_WIDTH-1:0] fast_res;

    assign fast_a   = {{WORD_WIDTH{a_neg}}, bus.opa_i};
    assign fast_b   = {{WORD_WIDTH{b_neg}}, bus.opb_i};
    assign fast_p   = fast_a * fast_b;
    assign fast_res = (bus.op_i == OP_MUL) ? fast_p[WORD_WIDTH-1:0] : fast_p[DW-1:WORD_WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    op_d  = bus.op_i;
                    neg_d = res_neg;
                    cnt_d = '0;
                    busy  = 1'b1;
                    if (bus.op_i[2]) begin
                        if (bus.opb_i == '0) begin
                            busy     = 1'b0;
                            result_d = bus.op_i[1] ? bus.opa_i : DIV_BY_ZERO_Q;
                            state_d  = DONE;
                        end else if (!bus.op_i[0] && (bus.opa_i == INT_MIN) && (bus.opb_i == '1)) begin
                            busy     = 1'b0;
                            result_d = bus.op_i[1] ? '0 : INT_MIN;
                            state_d  = DONE;
                        end else begin
                            opnd_d  = abs_b;
                            acc_d   = {{WORD_WIDTH{1'b0}}, abs_a};
                            state_d = DIV;
                        end
                    end else begin
`ifdef FAST_MUL_EN
                        result_d = fast_res;
                        state_d  = DONE;
`else
                        opnd_d  = abs_a;
                        acc_d   = {{WORD_WIDTH{1'b0}}, abs_b};
                        state_d = MUL;
`endif
                    end
                end
            end
            MUL, DIV: begin
                busy  = 1'b1;
                acc_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(WORD_WIDTH - 1)) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A redirect kills whatever is in flight and leaves the last result visible.
        if (bus.flush_i) begin
            state_d  = IDLE;
            result_d = result_q;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_o    = busy;
    assign bus.done_o    = (state_q == DONE) & ~bus.flush_i;
    assign bus.result_o  = result_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: results, latency, busy profile, specials, flush, reset, DONE behaviour.
// Expected values are hand-computed RV32M results; FAST_MUL_EN changes only the multiply timing.
module tb_ex_muldiv_unit;
    import riscv_defines::*;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_LAT  = 33;
    localparam int MUL_BUSY = 33;
`endif
    localparam int ITER_LAT = 33;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit_if bus ();

    ex_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input int exp_busy,
                          input string name);
        int lat;
        int busy_cnt;
        bus.op_i    = op;
        bus.opa_i   = a;
        bus.opb_i   = b;
        bus.start_i = 1'b1;
        #1;
        busy_cnt = bus.busy_o ? 1 : 0;
        tick();
        bus.start_i = 1'b0;
        lat = 1;
        while (!bus.done_o && lat < 100) begin
            if (bus.busy_o) busy_cnt++;
            tick();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (bus.result_o !== exp_res) begin
            failures++;
            $display("FAIL %s result: got %h expected %h", name, bus.result_o, exp_res);
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            failures++;
            $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s busy in done: got %b expected 0", name, bus.busy_o);
        end
        tick();
        checks++;
        if (bus.done_o !== 1'b0 || bus.state_dbg !== IDLE) begin
            failures++;
            $display("FAIL %s after done: got done=%b state=%0d expected done=0 state=0",
                     name, bus.done_o, bus.state_dbg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== IDLE || bus.done_o !== 1'b0 || bus.result_o !== 32'h0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset: got state=%0d done=%b result=%h busy=%b expected 0/0/00000000/0",
                     bus.state_dbg, bus.done_o, bus.result_o, bus.busy_o);
        end
    endtask

    task automatic test_mul();
        run_op(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, MUL_BUSY, "mul_7x-3");
        run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, MUL_BUSY, "mulhu_max");
        run_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, MUL_BUSY, "mulh_-1x-1");
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, MUL_BUSY, "mulhsu_-1xmax");
        run_op(OP_MUL,    32'h0001_0000, 32'h0001_0003, 32'h0003_0000, MUL_LAT, MUL_BUSY, "mul_wrap");
    endtask

    task automatic test_div();
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, ITER_LAT, ITER_LAT, "div_-7/2");
        run_op(OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, ITER_LAT, ITER_LAT, "rem_-7/2");
        run_op(OP_DIVU, 32'd100,       32'd7,         32'd14,        ITER_LAT, ITER_LAT, "divu_100/7");
        run_op(OP_REMU, 32'd100,       32'd7,         32'd2,         ITER_LAT, ITER_LAT, "remu_100/7");
        run_op(OP_DIV,  32'd20,        32'hFFFF_FFFB, 32'hFFFF_FFFC, ITER_LAT, ITER_LAT, "div_20/-5");
    endtask

    task automatic test_div_special();
        run_op(OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, 0, "div_5/0");
        run_op(OP_REM,  32'd5,         32'd0,         32'd5,         1, 0, "rem_5/0");
        run_op(OP_DIVU, 32'd9,         32'd0,         32'hFFFF_FFFF, 1, 0, "divu_9/0");
        run_op(OP_REMU, 32'd9,         32'd0,         32'd9,         1, 0, "remu_9/0");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, "rem_ovf");
    endtask

    task automatic test_flush();
        int done_seen;
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, ITER_LAT, ITER_LAT, "flush_prep");
        bus.op_i    = OP_DIVU;
        bus.opa_i   = 32'h0000_FFFF;
        bus.opb_i   = 32'd3;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        bus.flush_i = 1'b1;
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
            failures++;
            $display("FAIL flush same cycle: got busy=%b done=%b expected 0/0", bus.busy_o, bus.done_o);
        end
        tick();
        bus.flush_i = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== IDLE || bus.done_o !== 1'b0 || bus.result_o !== 32'd14 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL flush next cycle: got state=%0d done=%b result=%h busy=%b expected 0/0/0000000e/0",
                     bus.state_dbg, bus.done_o, bus.result_o, bus.busy_o);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done_o) done_seen++;
            tick();
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL flush no done: got %0d pulses expected 0", done_seen);
        end
        run_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, ITER_LAT, ITER_LAT, "after_flush");
    endtask

    task automatic test_rst_mid_op();
`ifdef FAST_MUL_EN
        bus.op_i  = OP_DIVU;
`else
        bus.op_i  = OP_MUL;
`endif
        bus.opa_i   = 32'd5;
        bus.opb_i   = 32'd6;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== IDLE || bus.done_o !== 1'b0 || bus.result_o !== 32'h0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst mid op: got state=%0d done=%b result=%h busy=%b expected 0/0/00000000/0",
                     bus.state_dbg, bus.done_o, bus.result_o, bus.busy_o);
        end
        run_op(OP_MUL, 32'd5, 32'd6, 32'd30, MUL_LAT, MUL_BUSY, "mul_after_rst");
    endtask

    task automatic test_start_in_done();
        bus.op_i    = OP_DIV;
        bus.opa_i   = 32'd5;
        bus.opb_i   = 32'd0;
        bus.start_i = 1'b1;
        tick();
        checks++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.result_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL done with start held: got done=%b busy=%b result=%h expected 1/0/ffffffff",
                     bus.done_o, bus.busy_o, bus.result_o);
        end
        tick();
        bus.start_i = 1'b0;
        #1;
        checks++;
        if (bus.state_dbg !== IDLE || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL no restart from done: got state=%0d done=%b busy=%b expected 0/0/0",
                     bus.state_dbg, bus.done_o, bus.busy_o);
        end
        tick();
        checks++;
        if (bus.done_o !== 1'b0 || bus.state_dbg !== IDLE) begin
            failures++;
            $display("FAIL single done pulse: got done=%b state=%0d expected 0/0", bus.done_o, bus.state_dbg);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, ITER_LAT, ITER_LAT, "b2b_remu");
        run_op(OP_MULHU, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, MUL_LAT, MUL_BUSY, "b2b_mulhu");
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, ITER_LAT, ITER_LAT, "b2b_divu");
    endtask

    initial begin
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.op_i    = OP_MUL;
        bus.opa_i   = '0;
        bus.opb_i   = '0;
        test_reset();
        test_mul();
        test_div();
        test_div_special();
        test_flush();
        test_rst_mid_op();
        test_start_in_done();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
